// File: rtl/br_pkg.sv
// Shared types and helpers for the ID-stage branch resolution controller.
// Holds the FSM state encoding, comparator op codes and operand-need decode.
package br_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2
    } br_state_e;

    localparam logic [2:0] OP_EQ  = 3'b110;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LEZ = 3'b010;
    localparam logic [2:0] OP_GTZ = 3'b011;
    localparam logic [2:0] OP_LTZ = 3'b100;
    localparam logic [2:0] OP_GEZ = 3'b101;

    // Two-operand compares also need rt.
    function automatic logic needs_rt(input logic [2:0] op);
        return (op == OP_EQ) || (op == OP_NE);
    endfunction

    // Every real branch op reads rs; unknown ops read nothing.
    function automatic logic op_valid(input logic [2:0] op);
        logic v;
        v = 1'b0;
        unique case (op)
            OP_EQ, OP_NE, OP_LEZ,
            OP_GTZ, OP_LTZ, OP_GEZ: v = 1'b1;
            default:                v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic operands_ready(
        input logic [2:0] op,
        input logic       rs_rdy,
        input logic       rt_rdy
    );
        return (!op_valid(op) || rs_rdy) && (!needs_rt(op) || rt_rdy);
    endfunction

endpackage

// File: rtl/br_wait_timer.sv
// Operand-wait cycle counter for the branch resolution controller.
// Counts while enabled, clears otherwise, flags the final allowed cycle.
module br_wait_timer #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Count consecutive unresolved wait cycles; any other cycle clears.
    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Sequences the external ID-stage branch comparator and issues PC select/flush.
// Optional macro BR_STATS_EN adds taken/total branch counters.
module branch_resolve_ctrl
    import br_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [2:0]  br_op,
    input  logic [31:0] br_target,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rs_rdy,
    input  logic        rt_rdy,
    input  logic        kill,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    output logic [2:0]  cmp_op,
    input  logic        cmp_br,
    output logic        stall,
    output logic        br_done,
    output logic        br_taken,
    output logic        npc_sel,
    output logic [31:0] npc_target,
    output logic        flush_ifid,
`ifdef BR_STATS_EN
    output logic [31:0] stat_taken,
    output logic [31:0] stat_total,
`endif
    output logic        wait_err
);

    br_state_e   state_q;
    logic [31:0] cmp_a_q;
    logic [31:0] cmp_b_q;
    logic [2:0]  cmp_op_q;
    logic [31:0] npc_target_q;
    logic        br_done_q;
    logic        br_taken_q;
    logic        wait_err_q;

    logic rdy_idle;
    logic rdy_wait;
    logic tmr_en;
    logic tmr_expire;
    logic accept;

    assign rdy_idle = operands_ready(br_op, rs_rdy, rt_rdy);
    assign rdy_wait = operands_ready(cmp_op_q, rs_rdy, rt_rdy);
    assign accept   = br_valid && !br_done_q;
    assign tmr_en   = (state_q == WAIT) && !kill && !rdy_wait;

    br_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    // Branch FSM with registered comparator operands and result pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            cmp_op_q     <= '0;
            npc_target_q <= '0;
            br_done_q    <= 1'b0;
            br_taken_q   <= 1'b0;
            wait_err_q   <= 1'b0;
        end else begin
            br_done_q  <= 1'b0;
            br_taken_q <= 1'b0;
            wait_err_q <= 1'b0;
            if (kill) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            cmp_op_q     <= br_op;
                            npc_target_q <= br_target;
                            if (rdy_idle) begin
                                cmp_a_q <= rs_val;
                                cmp_b_q <= rt_val;
                                state_q <= EVAL;
                            end else begin
                                state_q <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (rdy_wait) begin
                            cmp_a_q <= rs_val;
                            cmp_b_q <= rt_val;
                            state_q <= EVAL;
                        end else if (tmr_expire) begin
                            wait_err_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                    EVAL: begin
                        br_done_q  <= 1'b1;
                        br_taken_q <= cmp_br && op_valid(cmp_op_q);
                        state_q    <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef BR_STATS_EN
    logic [31:0] stat_taken_q;
    logic [31:0] stat_total_q;

    // Running counts of resolved and taken branches, wrapping naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_taken_q <= '0;
            stat_total_q <= '0;
        end else if (br_done_q) begin
            stat_total_q <= stat_total_q + 32'd1;
            if (br_taken_q) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end
        end
    end

    assign stat_taken = stat_taken_q;
    assign stat_total = stat_total_q;
`endif

    // Fetch/decode hold; released in the resolve cycle so fetch sees npc_sel.
    assign stall = (state_q != IDLE) || (br_valid && !br_done_q);

    assign cmp_a      = cmp_a_q;
    assign cmp_b      = cmp_b_q;
    assign cmp_op     = cmp_op_q;
    assign npc_target = npc_target_q;
    assign br_done    = br_done_q;
    assign br_taken   = br_taken_q;
    assign npc_sel    = br_done_q && br_taken_q;
    assign flush_ifid = br_done_q && br_taken_q;
    assign wait_err   = wait_err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl with an external comparator model.
// Stats checks are compiled in when BR_STATS_EN is defined.
module tb_branch_resolve_ctrl;
    import br_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_op = '0;
    logic [31:0] br_target = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        rs_rdy = 1'b0;
    logic        rt_rdy = 1'b0;
    logic        kill = 1'b0;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [2:0]  cmp_op;
    logic        cmp_br;
    logic        stall;
    logic        br_done;
    logic        br_taken;
    logic        npc_sel;
    logic [31:0] npc_target;
    logic        flush_ifid;
    logic        wait_err;
`ifdef BR_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_total;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;
    exp_t sb[$];

    branch_resolve_ctrl #(.MAX_WAIT(4), .WAIT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .br_valid   (br_valid),
        .br_op      (br_op),
        .br_target  (br_target),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .rs_rdy     (rs_rdy),
        .rt_rdy     (rt_rdy),
        .kill       (kill),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .cmp_op     (cmp_op),
        .cmp_br     (cmp_br),
        .stall      (stall),
        .br_done    (br_done),
        .br_taken   (br_taken),
        .npc_sel    (npc_sel),
        .npc_target (npc_target),
        .flush_ifid (flush_ifid),
`ifdef BR_STATS_EN
        .stat_taken (stat_taken),
        .stat_total (stat_total),
`endif
        .wait_err   (wait_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External signed comparator; unknown ops answer 1 to expose gating.
    always_comb begin
        cmp_br = 1'b1;
        case (cmp_op)
            3'b110:  cmp_br = (cmp_a == cmp_b);
            3'b001:  cmp_br = (cmp_a != cmp_b);
            3'b010:  cmp_br = ($signed(cmp_a) <= 0);
            3'b011:  cmp_br = ($signed(cmp_a) > 0);
            3'b100:  cmp_br = ($signed(cmp_a) < 0);
            3'b101:  cmp_br = ($signed(cmp_a) >= 0);
            default: cmp_br = 1'b1;
        endcase
    end

    // Scoreboard monitor: every br_done must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (br_done) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_br_done cyc=%0d taken=%b", cyc, br_taken);
                end else begin
                    e = sb.pop_front();
                    if (cyc !== e.due || br_taken !== e.taken ||
                        npc_sel !== e.taken || flush_ifid !== e.taken ||
                        npc_target !== e.tgt) begin
                        failures++;
                        $display("FAIL br_resolve got cyc=%0d taken=%b npc_sel=%b flush=%b tgt=%h, expected cyc=%0d taken=%b tgt=%h",
                                 cyc, br_taken, npc_sel, flush_ifid, npc_target,
                                 e.due, e.taken, e.tgt);
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                checks++;
                failures++;
                $display("FAIL missing_br_done cyc=%0d expected at %0d", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [2:0] op, input logic [31:0] tgt,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic ra, input logic rb);
        br_valid  = 1'b1;
        br_op     = op;
        br_target = tgt;
        rs_val    = a;
        rt_val    = b;
        rs_rdy    = ra;
        rt_rdy    = rb;
    endtask

    task automatic check_idle_outputs(input string tag);
        logic [5:0] bits;
        bits = {stall, br_done, br_taken, npc_sel, flush_ifid, wait_err};
        checks++;
        if (cmp_a !== 32'h0 || cmp_b !== 32'h0) begin
            failures++;
            $display("FAIL %s_cmp_ab got a=%h b=%h expected 0", tag, cmp_a, cmp_b);
        end
        checks++;
        if (cmp_op !== 3'b000) begin
            failures++;
            $display("FAIL %s_cmp_op got %b expected 000", tag, cmp_op);
        end
        checks++;
        if (npc_target !== 32'h0) begin
            failures++;
            $display("FAIL %s_npc_target got %h expected 0", tag, npc_target);
        end
        checks++;
        if (bits !== 6'b0) begin
            failures++;
            $display("FAIL %s_flags got %b expected 000000", tag, bits);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b1;
        tick();
    endtask

    task automatic test_eq_taken();
        int t;
        drive_br(OP_EQ, 32'h0000_4000, 32'h5, 32'h5, 1'b1, 1'b1);
        t = cyc;
        sb.push_back('{t + 2, 1'b1, 32'h0000_4000});
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL eq_stall_accept got %b expected 1", stall);
        end
        tick();
        br_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || cmp_a !== 32'h5 || cmp_op !== OP_EQ) begin
            failures++;
            $display("FAIL eq_eval got stall=%b a=%h op=%b expected 1 5 110", stall, cmp_a, cmp_op);
        end
        tick();
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL eq_stall_done got %b expected 0", stall);
        end
        tick();
    endtask

    task automatic test_gtz_no_rt();
        int t;
        drive_br(OP_GTZ, 32'h0000_8000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        t = cyc;
        sb.push_back('{t + 2, 1'b0, 32'h0000_8000});
        tick();
        br_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ne_wait();
        int t;
        logic [4:0] s;
        drive_br(OP_NE, 32'h0000_2000, 32'h1, 32'h2, 1'b0, 1'b1);
        t = cyc;
        sb.push_back('{t + 4, 1'b1, 32'h0000_2000});
        for (int i = 0; i < 5; i++) begin
            #1;
            s[i] = stall;
            tick();
            br_valid = 1'b0;
            if (i == 1) rs_rdy = 1'b1;
        end
        checks++;
        if (s !== 5'b01111) begin
            failures++;
            $display("FAIL ne_wait_stall got %b expected 01111", s);
        end
    endtask

    task automatic test_timeout();
        logic [6:0] w;
        logic [6:0] st;
        logic [6:0] d;
        drive_br(OP_LTZ, 32'h0000_3000, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            #1;
            w[i]  = wait_err;
            st[i] = stall;
            d[i]  = br_done;
            tick();
            br_valid = 1'b0;
        end
        checks++;
        if (w !== 7'b0100000) begin
            failures++;
            $display("FAIL timeout_wait_err got %b expected 0100000", w);
        end
        checks++;
        if (st !== 7'b0011111) begin
            failures++;
            $display("FAIL timeout_stall got %b expected 0011111", st);
        end
        checks++;
        if (d !== 7'b0) begin
            failures++;
            $display("FAIL timeout_br_done got %b expected 0000000", d);
        end
        rs_rdy = 1'b1;
    endtask

    task automatic test_kill_eval();
        drive_br(OP_EQ, 32'h0000_5000, 32'h7, 32'h7, 1'b1, 1'b1);
        tick();
        br_valid = 1'b0;
        kill = 1'b1;
        tick();
        kill = 1'b0;
        #1;
        checks++;
        if (br_done !== 1'b0 || stall !== 1'b0 || npc_sel !== 1'b0) begin
            failures++;
            $display("FAIL kill_eval got done=%b stall=%b npc_sel=%b expected 0 0 0",
                     br_done, stall, npc_sel);
        end
        tick();
        #1;
        checks++;
        if (br_done !== 1'b0) begin
            failures++;
            $display("FAIL kill_eval_late got done=%b expected 0", br_done);
        end
    endtask

    task automatic test_reset_wait();
        drive_br(OP_NE, 32'h0000_6000, 32'h3, 32'h3, 1'b0, 1'b0);
        tick();
        br_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        #1;
        check_idle_outputs("reset_wait");
        reset = 1'b1;
        rs_rdy = 1'b1;
        rt_rdy = 1'b1;
        tick();
    endtask

    task automatic test_invalid_op();
        int t;
        drive_br(3'b111, 32'h0000_7000, 32'h1, 32'h2, 1'b1, 1'b1);
        t = cyc;
        sb.push_back('{t + 2, 1'b0, 32'h0000_7000});
        tick();
        br_valid = 1'b0;
        tick();
        tick();
`ifdef BR_STATS_EN
        checks++;
        if (stat_total !== 32'd1 || stat_taken !== 32'd0) begin
            failures++;
            $display("FAIL stats_invalid got total=%0d taken=%0d expected 1 0",
                     stat_total, stat_taken);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int t;
        drive_br(OP_EQ, 32'h0000_9000, 32'h4, 32'h4, 1'b1, 1'b1);
        t = cyc;
        sb.push_back('{t + 2, 1'b1, 32'h0000_9000});
        tick();
        tick();
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall_done got %b expected 0", stall);
        end
        tick();
        rt_val    = 32'h6;
        br_target = 32'h0000_9100;
        sb.push_back('{t + 5, 1'b0, 32'h0000_9100});
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stall_accept got %b expected 1", stall);
        end
        tick();
        br_valid = 1'b0;
        tick();
        tick();
`ifdef BR_STATS_EN
        checks++;
        if (stat_total !== 32'd3 || stat_taken !== 32'd1) begin
            failures++;
            $display("FAIL stats_b2b got total=%0d taken=%0d expected 3 1",
                     stat_total, stat_taken);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_eq_taken();
        test_gtz_no_rt();
        test_ne_wait();
        test_timeout();
        test_kill_eval();
        test_reset_wait();
        test_invalid_op();
        test_back_to_back();
        tick();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
